// File: rtl/hub75_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : hub75_rx_if
//  Description : Pixel stream bundle (valid/ready) leaving the HUB75 receiver.
//  Revision    : 1.0
// ============================================================================
interface hub75_rx_if #(
    parameter int ROW_W = 4,
    parameter int COL_W = 6
);
    logic             px_valid;
    logic             px_ready;
    logic [ROW_W-1:0] px_row;
    logic [COL_W-1:0] px_col;
    logic [2:0]       px_top;
    logic [2:0]       px_btm;
    logic             px_last;

    modport master (
        output px_valid, px_row, px_col, px_top, px_btm, px_last,
        input  px_ready
    );

    modport slave (
        input  px_valid, px_row, px_col, px_top, px_btm, px_last,
        output px_ready
    );
endinterface
`default_nettype wire

// File: rtl/hub75_rx.sv
`default_nettype none
// ============================================================================
//  Module      : hub75_rx
//  Description : HUB75 panel-side receiver; deserialises one row pair per
//                latch and streams it out as pixels over valid/ready.
//  Revision    : 1.0
// ============================================================================
module hub75_rx #(
    parameter int COLS  = 64,
    parameter int ROW_W = 4,
    parameter int COL_W = $clog2(COLS)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             sclk,
    input  wire logic             latch,
    input  wire logic             blank,
    input  wire logic [2:0]       din_top,
    input  wire logic [2:0]       din_btm,
    input  wire logic [ROW_W-1:0] row_sel,
    hub75_rx_if.master            px,
    output logic                  lit,
    output logic                  shift_err,
    output logic                  ovf_err,
    input  wire logic             err_clr
);

    localparam logic [COL_W:0]   c_cols     = (COL_W+1)'(COLS);
    localparam logic [COL_W:0]   c_cnt_max  = '1;
    localparam logic [COL_W-1:0] c_last_col = COL_W'(COLS-1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t r_state;

    // Input sampling: control strobes get two stages for edge detection,
    // payload is taken from the first stage so it lines up with the edge.
    logic             r_sclk_q1, r_sclk_q2;
    logic             r_latch_q1, r_latch_q2;
    logic             r_blank_q1;
    logic [2:0]       r_top_q1, r_btm_q1;
    logic [ROW_W-1:0] r_row_q1;

    logic [COLS-1:0][2:0] r_sh_top, r_sh_btm;
    logic [COLS-1:0][2:0] r_snap_top, r_snap_btm;
    logic [COLS-1:0][2:0] w_sh_top_nxt, w_sh_btm_nxt;
    logic [COL_W:0]       r_cnt, w_cnt_nxt;

    logic             r_px_valid, r_px_last;
    logic [ROW_W-1:0] r_px_row;
    logic [COL_W-1:0] r_px_col;
    logic [2:0]       r_px_top, r_px_btm;
    logic             r_lit, r_shift_err, r_ovf_err;

    logic             w_sclk_rise, w_latch_rise;
    logic             w_shift_set, w_ovf_set;
    logic [COL_W-1:0] w_col_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_q1  <= 1'b0;
            r_sclk_q2  <= 1'b0;
            r_latch_q1 <= 1'b0;
            r_latch_q2 <= 1'b0;
            r_blank_q1 <= 1'b0;
            r_top_q1   <= '0;
            r_btm_q1   <= '0;
            r_row_q1   <= '0;
        end else begin
            r_sclk_q1  <= sclk;
            r_sclk_q2  <= r_sclk_q1;
            r_latch_q1 <= latch;
            r_latch_q2 <= r_latch_q1;
            r_blank_q1 <= blank;
            r_top_q1   <= din_top;
            r_btm_q1   <= din_btm;
            r_row_q1   <= row_sel;
        end
    end

    assign w_sclk_rise  = r_sclk_q1 & ~r_sclk_q2;
    assign w_latch_rise = r_latch_q1 & ~r_latch_q2;

    // Shift result for this cycle; a coincident latch snapshots this value,
    // so the bit arriving with the latch is included.
    assign w_sh_top_nxt = w_sclk_rise ? {r_sh_top[COLS-2:0], r_top_q1} : r_sh_top;
    assign w_sh_btm_nxt = w_sclk_rise ? {r_sh_btm[COLS-2:0], r_btm_q1} : r_sh_btm;
    assign w_cnt_nxt    = (w_sclk_rise && (r_cnt != c_cnt_max)) ? r_cnt + 1'b1 : r_cnt;

    assign w_shift_set = w_latch_rise && (r_state == S_IDLE) && (w_cnt_nxt != c_cols);
    assign w_ovf_set   = w_latch_rise && (r_state == S_STREAM);
    assign w_col_inc   = r_px_col + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sh_top    <= '0;
            r_sh_btm    <= '0;
            r_snap_top  <= '0;
            r_snap_btm  <= '0;
            r_cnt       <= '0;
            r_px_valid  <= 1'b0;
            r_px_last   <= 1'b0;
            r_px_row    <= '0;
            r_px_col    <= '0;
            r_px_top    <= '0;
            r_px_btm    <= '0;
            r_lit       <= 1'b0;
            r_shift_err <= 1'b0;
            r_ovf_err   <= 1'b0;
        end else begin
            r_sh_top    <= w_sh_top_nxt;
            r_sh_btm    <= w_sh_btm_nxt;
            r_cnt       <= w_cnt_nxt;
            r_lit       <= ~r_blank_q1;
            // Sticky flags: a new event outranks a simultaneous clear.
            r_shift_err <= w_shift_set | (r_shift_err & ~err_clr);
            r_ovf_err   <= w_ovf_set   | (r_ovf_err   & ~err_clr);

            case (r_state)
                S_IDLE: begin
                    if (w_latch_rise) begin
                        r_snap_top <= w_sh_top_nxt;
                        r_snap_btm <= w_sh_btm_nxt;
                        r_px_row   <= r_row_q1;
                        r_cnt      <= '0;
                        r_px_valid <= 1'b1;
                        r_px_col   <= '0;
                        r_px_top   <= w_sh_top_nxt[0];
                        r_px_btm   <= w_sh_btm_nxt[0];
                        r_px_last  <= (COLS == 1);
                        r_state    <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (r_px_valid && px.px_ready) begin
                        if (r_px_col == c_last_col) begin
                            r_px_valid <= 1'b0;
                            r_px_last  <= 1'b0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_px_col  <= w_col_inc;
                            r_px_top  <= r_snap_top[w_col_inc];
                            r_px_btm  <= r_snap_btm[w_col_inc];
                            r_px_last <= (w_col_inc == c_last_col);
                        end
                    end
                end
            endcase
        end
    end

    assign px.px_valid = r_px_valid;
    assign px.px_row   = r_px_row;
    assign px.px_col   = r_px_col;
    assign px.px_top   = r_px_top;
    assign px.px_btm   = r_px_btm;
    assign px.px_last  = r_px_last;
    assign lit         = r_lit;
    assign shift_err   = r_shift_err;
    assign ovf_err     = r_ovf_err;

endmodule
`default_nettype wire

// File: tb/tb_hub75_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hub75_rx
//  Description : Self-checking bench for hub75_rx against a queue-based model.
//  Revision    : 1.0
// ============================================================================
module tb_hub75_rx;
    localparam int COLS  = 64;
    localparam int ROW_W = 4;
    localparam int COL_W = 6;

    logic             clk = 1'b0, rst_n = 1'b0;
    logic             sclk = 1'b0, latch = 1'b0, blank = 1'b1, err_clr = 1'b0;
    logic [2:0]       din_top = '0, din_btm = '0;
    logic [ROW_W-1:0] row_sel = '0;
    wire logic        lit, shift_err, ovf_err;

    hub75_rx_if #(.ROW_W(ROW_W), .COL_W(COL_W)) px_if ();

    hub75_rx #(.COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .latch     (latch),
        .blank     (blank),
        .din_top   (din_top),
        .din_btm   (din_btm),
        .row_sel   (row_sel),
        .px        (px_if),
        .lit       (lit),
        .shift_err (shift_err),
        .ovf_err   (ovf_err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: history of every shifted value, plus expected rows.
    logic [2:0]        hist_top[$];
    logic [2:0]        hist_btm[$];
    int                shifts_since = 0;
    logic              exp_shift_err = 1'b0;
    logic              exp_ovf_err   = 1'b0;
    logic [ROW_W-1:0]  q_row[$];
    logic [3*COLS-1:0] q_top[$];
    logic [3*COLS-1:0] q_btm[$];
    int                ready_mode  = 0;
    int                beats_in_row = 0;

    // Column c holds the c-th most recent shifted value (zero if never shifted).
    function automatic logic [2:0] hist_at(input bit top, input int c);
        int idx;
        idx = hist_top.size() - 1 - c;
        if (idx < 0) return 3'd0;
        return top ? hist_top[idx] : hist_btm[idx];
    endfunction

    task automatic model_shift(input logic [2:0] t, input logic [2:0] b);
        hist_top.push_back(t);
        hist_btm.push_back(b);
        shifts_since++;
    endtask

    task automatic model_latch(input logic [ROW_W-1:0] row);
        logic [3*COLS-1:0] st, sb;
        if (q_row.size() != 0) begin
            exp_ovf_err = 1'b1;
        end else begin
            for (int c = 0; c < COLS; c++) begin
                st[3*c +: 3] = hist_at(1'b1, c);
                sb[3*c +: 3] = hist_at(1'b0, c);
            end
            q_row.push_back(row);
            q_top.push_back(st);
            q_btm.push_back(sb);
            if (shifts_since != COLS) exp_shift_err = 1'b1;
            shifts_since = 0;
        end
    endtask

    // Monitor: drives px_ready, checks accepted beats and stall stability.
    logic        p_valid = 1'b0, p_acc = 1'b0;
    logic [31:0] p_snap = '0;
    int          exp_col = 0;
    int          phase   = 0;

    always @(negedge clk) begin
        logic        r, acc;
        logic [31:0] snap;
        logic [3*COLS-1:0] et, eb;
        if (!rst_n) begin
            p_valid         = 1'b0;
            p_acc           = 1'b0;
            exp_col         = 0;
            beats_in_row    = 0;
            px_if.px_ready  = 1'b0;
        end else begin
            snap = {12'd0, px_if.px_row, px_if.px_col, px_if.px_top, px_if.px_btm,
                    px_if.px_last, px_if.px_valid};
            if (p_valid && !p_acc) check("stall_hold", snap, p_snap);
            if (q_row.size() == 0) check("valid_idle", {31'd0, px_if.px_valid}, 32'd0);
            case (ready_mode)
                0: r = 1'b1;
                1: begin r = (phase == 0); phase = (phase + 1) % 3; end
                2: r = 1'($urandom_range(0, 1));
                default: r = 1'b0;
            endcase
            px_if.px_ready = r;
            acc = px_if.px_valid && r;
            if (acc && q_row.size() != 0) begin
                et = q_top[0];
                eb = q_btm[0];
                check("px_row",  {28'd0, px_if.px_row}, {28'd0, q_row[0]});
                check("px_col",  {26'd0, px_if.px_col}, exp_col);
                check("px_top",  {29'd0, px_if.px_top}, {29'd0, et[3*exp_col +: 3]});
                check("px_btm",  {29'd0, px_if.px_btm}, {29'd0, eb[3*exp_col +: 3]});
                check("px_last", {31'd0, px_if.px_last}, (exp_col == COLS-1) ? 32'd1 : 32'd0);
                exp_col++;
                beats_in_row++;
                if (exp_col == COLS) begin
                    void'(q_row.pop_front());
                    void'(q_top.pop_front());
                    void'(q_btm.pop_front());
                    exp_col      = 0;
                    beats_in_row = 0;
                end
            end
            p_valid = px_if.px_valid;
            p_acc   = acc;
            p_snap  = snap;
        end
    end

    // Stimulus tasks: each starts and ends just after a falling clk edge.
    task automatic shift_bit(input logic [2:0] t, input logic [2:0] b);
        din_top = t;
        din_btm = b;
        sclk    = 1'b1;
        model_shift(t, b);
        repeat ($urandom_range(1, 2)) @(negedge clk);
        sclk = 1'b0;
        repeat ($urandom_range(1, 2)) @(negedge clk);
    endtask

    task automatic shift_rand(input int n);
        for (int i = 0; i < n; i++)
            shift_bit(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    endtask

    task automatic do_latch(input logic [ROW_W-1:0] row);
        row_sel = row;
        latch   = 1'b1;
        model_latch(row);
        repeat (2) @(negedge clk);
        latch = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_errs(input string tag);
        check({tag, "_shift_err"}, {31'd0, shift_err}, {31'd0, exp_shift_err});
        check({tag, "_ovf_err"},   {31'd0, ovf_err},   {31'd0, exp_ovf_err});
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr       = 1'b0;
        exp_shift_err = 1'b0;
        exp_ovf_err   = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while ((q_row.size() != 0 || px_if.px_valid) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_idle_timeout"}, {31'd0, t < 4000}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, {31'd0, px_if.px_valid}, 32'd0);
        check({tag, "_row"},   {28'd0, px_if.px_row},   32'd0);
        check({tag, "_col"},   {26'd0, px_if.px_col},   32'd0);
        check({tag, "_top"},   {29'd0, px_if.px_top},   32'd0);
        check({tag, "_btm"},   {29'd0, px_if.px_btm},   32'd0);
        check({tag, "_last"},  {31'd0, px_if.px_last},  32'd0);
        check({tag, "_lit"},   {31'd0, lit},            32'd0);
        check({tag, "_serr"},  {31'd0, shift_err},      32'd0);
        check({tag, "_oerr"},  {31'd0, ovf_err},        32'd0);
    endtask

    initial begin
        logic [ROW_W-1:0] row_a;
        int               t;
        logic             b;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // lit follows blank inverted, two cycles later
        for (int i = 0; i < 4; i++) begin
            b     = 1'($urandom_range(0, 1));
            blank = b;
            repeat (2) @(negedge clk);
            check("lit", {31'd0, lit}, {31'd0, ~b});
        end
        blank = 1'b0;

        // Baseline row: top=col%8, btm=7-col%8, column 63 shifted first
        ready_mode = 0;
        for (int i = 0; i < COLS; i++)
            shift_bit(3'((COLS-1-i) % 8), 3'(7 - ((COLS-1-i) % 8)));
        do_latch(4'd5);
        check_errs("base");
        wait_idle("base");

        // Backpressure 1,0,0 then random readiness on random rows
        ready_mode = 1;
        for (int i = 0; i < COLS; i++)
            shift_bit(3'((COLS-1-i) % 8), 3'(7 - ((COLS-1-i) % 8)));
        do_latch(4'd5);
        wait_idle("bp");
        ready_mode = 2;
        for (int k = 0; k < 3; k++) begin
            shift_rand(COLS);
            do_latch(ROW_W'($urandom_range(0, 15)));
            wait_idle("rand");
        end
        check_errs("rand");

        // Short row
        ready_mode = 0;
        shift_rand(COLS - 1);
        do_latch(4'd9);
        check("short_shift_err", {31'd0, shift_err}, 32'd1);
        wait_idle("short");
        pulse_clr();
        check_errs("short_clr");

        // Overrun: second latch while the first row is stalled
        ready_mode = 3;
        shift_rand(COLS);
        row_a = ROW_W'($urandom_range(0, 15));
        do_latch(row_a);
        repeat (10) @(negedge clk);
        shift_rand(5);
        do_latch(~row_a);
        check("ovf_set", {31'd0, ovf_err}, 32'd1);
        check("ovf_row_kept", {28'd0, px_if.px_row}, {28'd0, row_a});
        check("ovf_valid", {31'd0, px_if.px_valid}, 32'd1);
        ready_mode = 0;
        wait_idle("ovf");
        check_errs("ovf");
        shift_rand(COLS);
        do_latch(4'd2);
        wait_idle("post_ovf");
        check_errs("post_ovf");
        pulse_clr();

        // Collision: 64th sclk rise lands together with the latch rise
        shift_rand(COLS - 1);
        din_top = 3'($urandom_range(0, 7));
        din_btm = 3'($urandom_range(0, 7));
        row_sel = 4'd12;
        sclk    = 1'b1;
        latch   = 1'b1;
        model_shift(din_top, din_btm);
        model_latch(4'd12);
        repeat (2) @(negedge clk);
        sclk  = 1'b0;
        latch = 1'b0;
        repeat (2) @(negedge clk);
        check("coll_shift_err", {31'd0, shift_err}, {31'd0, exp_shift_err});
        wait_idle("coll");

        // err_clr in the same cycle as an overrun event: the set wins
        ready_mode = 3;
        shift_rand(COLS);
        do_latch(4'd7);
        latch = 1'b1;
        model_latch(4'd3);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr       = 1'b0;
        exp_shift_err = 1'b0;
        latch         = 1'b0;
        repeat (2) @(negedge clk);
        check("clr_vs_ovf", {31'd0, ovf_err}, 32'd1);
        check_errs("clr_vs_ovf");
        ready_mode = 0;
        wait_idle("clr_vs_ovf");
        pulse_clr();

        // Asynchronous reset in the middle of a stream
        blank = 1'b1;
        shift_rand(COLS);
        do_latch(4'd10);
        t = 0;
        while (beats_in_row < 20 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        check("beat20_timeout", {31'd0, t < 2000}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        q_row.delete();
        q_top.delete();
        q_btm.delete();
        hist_top.delete();
        hist_btm.delete();
        shifts_since  = 0;
        exp_shift_err = 1'b0;
        exp_ovf_err   = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        shift_rand(COLS);
        do_latch(4'd6);
        check_errs("after_rst");
        wait_idle("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
